neuron_sequencer: RTL and testbench

Time-multiplexed controller for one neuron. It replaces the fully parallel array of 784 multipliers and 783 adders with a single shared multiply-accumulate unit. It walks the input and weight memories address by address, accumulates the products, adds the bias with signed saturation, and applies ReLU. It sits between the layer controller (which issues `start`) and the per-neuron input and weight ROMs.

---
 rtl/neuron_pkg.sv | 16 +
 rtl/bias_sat_relu.sv | 30 +++
 rtl/neuron_sequencer.sv | 125 ++++++++++++
 tb/tb_neuron_sequencer.sv | 298 +++++++++++++++++++++++++++++
 4 files changed

// File: rtl/neuron_pkg.sv
// Shared constants and state encoding for the time-multiplexed neuron.
package neuron_pkg;

  localparam int unsigned DATA_W = 32;

  localparam logic [31:0] SAT_MAX = 32'h7FFF_FFFF;
  localparam logic [31:0] SAT_MIN = 32'h8000_0000;

  typedef enum logic [1:0] {
    StIdle,
    StIssue,
    StDrain,
    StFinish
  } state_e;

endpackage

// File: rtl/bias_sat_relu.sv
// Combinational signed saturating bias add, optionally followed by ReLU.
module bias_sat_relu #(
  parameter int unsigned DATA_W  = 32,
  parameter bit          RELU_EN = 1'b1
) (
  input  logic [DATA_W-1:0] acc,
  input  logic [DATA_W-1:0] bias,
  output logic [DATA_W-1:0] result
);

  // Saturation bounds for any width; at 32 bits these equal SAT_MAX / SAT_MIN.
  localparam logic [DATA_W-1:0] SatMax = {1'b0, {(DATA_W-1){1'b1}}};
  localparam logic [DATA_W-1:0] SatMin = {1'b1, {(DATA_W-1){1'b0}}};

  logic [DATA_W-1:0] sum;
  logic [DATA_W-1:0] sat;
  logic              ovf;

  // Overflow only when both operands share a sign that the wrapped sum loses.
  always_comb begin
    sum    = acc + bias;
    ovf    = (acc[DATA_W-1] == bias[DATA_W-1]) && (sum[DATA_W-1] != acc[DATA_W-1]);
    sat    = ovf ? (acc[DATA_W-1] ? SatMin : SatMax) : sum;
    result = sat;
    if (RELU_EN && sat[DATA_W-1]) begin
      result = '0;
    end
  end

endmodule

// File: rtl/neuron_sequencer.sv
// Single-MAC neuron: streams input/weight pairs from memory, accumulates,
// then applies saturating bias add and ReLU.
module neuron_sequencer #(
  parameter int unsigned NUM_INPUTS = 784,
  parameter int unsigned DATA_W     = neuron_pkg::DATA_W,
  parameter int unsigned ADDR_W     = 10
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              start,
  input  logic [DATA_W-1:0] bias_value,
  output logic              rd_en,
  output logic [ADDR_W-1:0] rd_addr,
  input  logic [DATA_W-1:0] in_data,
  input  logic [DATA_W-1:0] w_data,
  output logic              busy,
  output logic              done,
  output logic [DATA_W-1:0] result
);
  import neuron_pkg::*;

  localparam logic [ADDR_W-1:0] LastAddr = ADDR_W'(NUM_INPUTS - 1);

  state_e            state_q, state_d;
  logic              rd_en_q, rd_en_d;
  logic [ADDR_W-1:0] rd_addr_q, rd_addr_d;
  logic              valid_q;
  logic [DATA_W-1:0] acc_q, acc_d;
  logic [DATA_W-1:0] bias_q, bias_d;
  logic              busy_q, busy_d;
  logic              done_q, done_d;
  logic [DATA_W-1:0] result_q, result_d;

  logic [DATA_W-1:0] product;
  logic [DATA_W-1:0] post_act;

  // Low DATA_W bits of the signed product; upper bits are intentionally dropped.
  assign product = DATA_W'($signed(in_data) * $signed(w_data));

  bias_sat_relu #(
    .DATA_W  (DATA_W),
    .RELU_EN (1'b1)
  ) u_bias_sat_relu (
    .acc    (acc_q),
    .bias   (bias_q),
    .result (post_act)
  );

  // Next-state, address counter and accumulator control.
  always_comb begin
    state_d   = state_q;
    rd_en_d   = rd_en_q;
    rd_addr_d = rd_addr_q;
    acc_d     = valid_q ? (acc_q + product) : acc_q;
    bias_d    = bias_q;
    busy_d    = busy_q;
    done_d    = 1'b0;
    result_d  = result_q;

    unique case (state_q)
      StIdle: begin
        // busy may still be high here during the done cycle; a start keeps it up.
        busy_d = start;
        if (start) begin
          state_d   = StIssue;
          acc_d     = '0;
          bias_d    = bias_value;
          rd_addr_d = '0;
          rd_en_d   = 1'b1;
        end
      end
      StIssue: begin
        if (rd_addr_q == LastAddr) begin
          state_d   = StDrain;
          rd_en_d   = 1'b0;
          rd_addr_d = '0;
        end else begin
          rd_addr_d = rd_addr_q + ADDR_W'(1);
        end
      end
      StDrain: begin
        // The last response is accumulated on this edge.
        state_d = StFinish;
      end
      StFinish: begin
        result_d = post_act;
        done_d   = 1'b1;
        state_d  = StIdle;
      end
      default: state_d = StIdle;
    endcase
  end

  // State registers; reset also kills any in-flight memory response via valid_q.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q   <= StIdle;
      rd_en_q   <= 1'b0;
      rd_addr_q <= '0;
      valid_q   <= 1'b0;
      acc_q     <= '0;
      bias_q    <= '0;
      busy_q    <= 1'b0;
      done_q    <= 1'b0;
      result_q  <= '0;
    end else begin
      state_q   <= state_d;
      rd_en_q   <= rd_en_d;
      rd_addr_q <= rd_addr_d;
      valid_q   <= rd_en_q;
      acc_q     <= acc_d;
      bias_q    <= bias_d;
      busy_q    <= busy_d;
      done_q    <= done_d;
      result_q  <= result_d;
    end
  end

  assign rd_en   = rd_en_q;
  assign rd_addr = rd_addr_q;
  assign busy    = busy_q;
  assign done    = done_q;
  assign result  = result_q;

endmodule

// File: tb/tb_neuron_sequencer.sv
// Self-checking bench for neuron_sequencer with NUM_INPUTS = 4.
module tb_neuron_sequencer;
  import neuron_pkg::*;

  localparam int N  = 4;
  localparam int DW = 32;
  localparam int AW = 2;

  logic          clk;
  logic          rst;
  logic          start;
  logic [DW-1:0] bias_value;
  logic          rd_en;
  logic [AW-1:0] rd_addr;
  logic [DW-1:0] in_data;
  logic [DW-1:0] w_data;
  logic          busy;
  logic          done;
  logic [DW-1:0] result;

  int n_checks = 0;
  int n_fail   = 0;

  logic [DW-1:0] mem_in [N];
  logic [DW-1:0] mem_w  [N];

  neuron_sequencer #(
    .NUM_INPUTS (N),
    .DATA_W     (DW),
    .ADDR_W     (AW)
  ) dut (
    .clk        (clk),
    .rst        (rst),
    .start      (start),
    .bias_value (bias_value),
    .rd_en      (rd_en),
    .rd_addr    (rd_addr),
    .in_data    (in_data),
    .w_data     (w_data),
    .busy       (busy),
    .done       (done),
    .result     (result)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // One-cycle-latency memories; garbage when not read so ungated accumulation shows.
  always @(posedge clk) begin
    if (rd_en) begin
      in_data <= mem_in[rd_addr];
      w_data  <= mem_w[rd_addr];
    end else begin
      in_data <= $urandom;
      w_data  <= $urandom;
    end
  end

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation still running, want finished");
    $fatal(1, "watchdog");
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic load(input logic [DW-1:0] i0, i1, i2, i3, w0, w1, w2, w3);
    mem_in[0] = i0; mem_in[1] = i1; mem_in[2] = i2; mem_in[3] = i3;
    mem_w[0]  = w0; mem_w[1]  = w1; mem_w[2]  = w2; mem_w[3]  = w3;
  endtask

  // Reference: wrapped dot product, exact wide bias add clamped to range, then ReLU.
  function automatic logic [DW-1:0] model(input logic [DW-1:0] bias);
    logic [DW-1:0] acc;
    longint        s;
    acc = '0;
    for (int i = 0; i < N; i++) acc = acc + mem_in[i] * mem_w[i];
    s = longint'($signed(acc)) + longint'($signed(bias));
    if (s > 64'sd2147483647) s = 64'sd2147483647;
    if (s < -64'sd2147483648) s = -64'sd2147483648;
    if (s < 0) return '0;
    return s[DW-1:0];
  endfunction

  // One full run from an idle DUT, checking cycle-by-cycle handshake and the result.
  task automatic run_check(input string name, input logic [DW-1:0] bias,
                           input logic [DW-1:0] exp, input int pulse_edge);
    logic eb, ed, er;
    start      = 1'b1;
    bias_value = bias;
    tick();
    start      = 1'b0;
    bias_value = $urandom;
    for (int k = 0; k <= N + 3; k++) begin
      eb = (k <= N + 2);
      ed = (k == N + 2);
      er = (k < N);
      n_checks++;
      if (busy !== eb) begin
        n_fail++;
        $display("FAIL %s busy edge %0d: got %b want %b", name, k, busy, eb);
      end
      n_checks++;
      if (done !== ed) begin
        n_fail++;
        $display("FAIL %s done edge %0d: got %b want %b", name, k, done, ed);
      end
      n_checks++;
      if (rd_en !== er) begin
        n_fail++;
        $display("FAIL %s rd_en edge %0d: got %b want %b", name, k, rd_en, er);
      end
      if (er) begin
        n_checks++;
        if (rd_addr !== AW'(k)) begin
          n_fail++;
          $display("FAIL %s rd_addr edge %0d: got %0d want %0d", name, k, rd_addr, k);
        end
      end
      if (k >= N + 2) begin
        n_checks++;
        if (result !== exp) begin
          n_fail++;
          $display("FAIL %s result edge %0d: got %h want %h", name, k, result, exp);
        end
      end
      if (k < N + 3) begin
        if (k == pulse_edge - 1) start = 1'b1;
        tick();
        start = 1'b0;
      end
    end
  endtask

  task automatic test_reset();
    rst        = 1'b1;
    start      = 1'b0;
    bias_value = '0;
    tick();
    tick();
    n_checks++;
    if ({busy, done, rd_en, rd_addr, result} !== '0) begin
      n_fail++;
      $display("FAIL reset_state: got busy=%b done=%b rd_en=%b addr=%0d result=%h want all 0",
               busy, done, rd_en, rd_addr, result);
    end
    rst = 1'b0;
    tick();
  endtask

  task automatic test_directed();
    load(1, 2, 3, 4, 1, 1, 1, 1);
    run_check("sum10", 32'd0, 32'd10, -1);
    run_check("relu_clamp", 32'hFFFF_FFEC, 32'd0, -1);
    load(32'h7FFF_FFF0, 0, 0, 0, 1, 0, 0, 0);
    run_check("pos_sat", 32'h20, SAT_MAX, -1);
    load(32'h0001_0000, 0, 0, 0, 32'h0001_0000, 0, 0, 0);
    run_check("prod_wrap", 32'd5, 32'd5, -1);
    // Negative saturation is hidden by ReLU and must still read zero.
    load(32'h8000_0010, 0, 0, 0, 1, 0, 0, 0);
    run_check("neg_sat", 32'hFFFF_FF00, 32'd0, -1);
  endtask

  task automatic test_start_ignored();
    load(1, 2, 3, 4, 1, 1, 1, 1);
    run_check("start_ignored", 32'd0, 32'd10, 2);
  endtask

  task automatic test_reset_mid_run();
    logic [DW-1:0] b;
    load(5, 6, 7, 8, 2, 2, 2, 2);
    start = 1'b1;
    bias_value = 32'd1;
    tick();
    start = 1'b0;
    tick();
    tick();
    tick();
    rst = 1'b1;
    #1;
    n_checks++;
    if ({busy, done, rd_en, rd_addr, result} !== '0) begin
      n_fail++;
      $display("FAIL mid_reset_outputs: got busy=%b done=%b rd_en=%b addr=%0d result=%h want 0",
               busy, done, rd_en, rd_addr, result);
    end
    tick();
    rst = 1'b0;
    for (int k = 0; k < 10; k++) begin
      n_checks++;
      if (done !== 1'b0 || busy !== 1'b0) begin
        n_fail++;
        $display("FAIL mid_reset_quiet cycle %0d: got done=%b busy=%b want 0 0", k, done, busy);
      end
      tick();
    end
    for (int i = 0; i < N; i++) begin
      mem_in[i] = $urandom_range(0, 1000);
      mem_w[i]  = $urandom_range(0, 200) - 100;
    end
    b = $urandom_range(0, 4000) - 2000;
    run_check("after_reset", b, model(b), -1);
  endtask

  task automatic test_random();
    logic [DW-1:0] b;
    for (int r = 0; r < 10; r++) begin
      for (int i = 0; i < N; i++) begin
        if (r % 2 == 0) begin
          mem_in[i] = $urandom_range(0, 1000);
          mem_w[i]  = $urandom_range(0, 200) - 100;
        end else begin
          mem_in[i] = $urandom;
          mem_w[i]  = $urandom;
        end
      end
      b = (r % 2 == 0) ? ($urandom_range(0, 4000) - 2000) : $urandom;
      run_check($sformatf("random%0d", r), b, model(b), -1);
    end
  endtask

  task automatic test_back_to_back();
    int            done_edges[$];
    int            addrs[$];
    logic [DW-1:0] exp;
    load(3, 1, 4, 1, 5, 9, 2, 6);
    exp        = 32'd48;  // 15+9+8+6 plus bias 10
    start      = 1'b1;
    bias_value = 32'd10;
    tick();
    for (int k = 0; k <= 20; k++) begin
      n_checks++;
      if (busy !== 1'b1) begin
        n_fail++;
        $display("FAIL b2b busy edge %0d: got %b want 1", k, busy);
      end
      if (done) begin
        done_edges.push_back(k);
        n_checks++;
        if (result !== exp) begin
          n_fail++;
          $display("FAIL b2b result edge %0d: got %h want %h", k, result, exp);
        end
      end
      if (rd_en) addrs.push_back(int'(rd_addr));
      if (k == 20) start = 1'b0;
      else tick();
    end
    n_checks++;
    if (done_edges.size() != 3) begin
      n_fail++;
      $display("FAIL b2b done_count: got %0d want 3", done_edges.size());
    end else begin
      for (int i = 0; i < 3; i++) begin
        n_checks++;
        if (done_edges[i] != 6 + 7 * i) begin
          n_fail++;
          $display("FAIL b2b done_edge %0d: got %0d want %0d", i, done_edges[i], 6 + 7 * i);
        end
      end
    end
    n_checks++;
    if (addrs.size() != 3 * N) begin
      n_fail++;
      $display("FAIL b2b addr_count: got %0d want %0d", addrs.size(), 3 * N);
    end else begin
      for (int i = 0; i < 3 * N; i++) begin
        n_checks++;
        if (addrs[i] != i % N) begin
          n_fail++;
          $display("FAIL b2b addr %0d: got %0d want %0d", i, addrs[i], i % N);
        end
      end
    end
    tick();
    tick();
    n_checks++;
    if (busy !== 1'b0) begin
      n_fail++;
      $display("FAIL b2b idle_after: got busy=%b want 0", busy);
    end
  endtask

  initial begin
    test_reset();
    test_directed();
    test_start_ignored();
    test_reset_mid_run();
    test_random();
    test_back_to_back();
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
